// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and baud arithmetic.
// Imported by both the TX and RX paths of the link.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int DATA_BITS = 8;

  // Clocks per bit, integer-truncated.
  function automatic int bit_cycles(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_core_if.sv
// Byte write port of the UART transmitter: data/valid in, ready/overflow back.
interface uart_tx_core_if;

  logic [7:0] data_in;
  logic       valid;
  logic       ready;
  logic       overflow;

  modport master (output data_in, valid, input ready, overflow);
  modport slave  (input data_in, valid, output ready, overflow);

endinterface

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO, first-word fall-through (rd_data shows the head
// entry combinationally). Push is ignored when full, pop when empty.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    wr_data,
  input  logic          pop,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write.
  // NOTE: the array is deliberately not reset; contents are only visible
  // through count, and a reset here would block mapping onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter, LSB first, fed from a byte FIFO so the command side
// can burst writes. Frames run back-to-back while the FIFO has data.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 72_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  uart_tx_core_if.slave                      bus,
  output logic                               tx,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH + 1)-1:0]  fifo_count
);

  localparam int BIT_CYCLES = bit_cycles(CLK_FREQ_HZ, BAUD_RATE);
  localparam int BW         = (BIT_CYCLES < 2) ? 1 : $clog2(BIT_CYCLES);
  localparam int CW         = $clog2(FIFO_DEPTH + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_CYCLES - 1);

  if (BIT_CYCLES < 2) begin : g_bad_baud
    $error("uart_tx_core: CLK_FREQ_HZ / BAUD_RATE must be >= 2");
  end

  tx_state_t     state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          overflow_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [7:0]    fifo_rd;
  logic          baud_done;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (bus.valid),
    .wr_data (bus.data_in),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // ready comes from the registered count only, so a same-cycle pop never
  // opens a slot for a write into a full FIFO.
  assign bus.ready    = !fifo_full;
  assign bus.overflow = overflow_q;
  assign baud_done    = (baud_cnt == BAUD_LAST);

  // A new byte is taken when idle, or at the end of a stop bit so the next
  // start bit follows with no gap.
  assign fifo_pop = !fifo_empty &&
                    ((state == IDLE) || ((state == STOP) && baud_done));

  // Built only from flops, so it changes on the same edges as state/count.
  assign busy = (state != IDLE) || (fifo_count != '0);

  // One-cycle flag for a write that hit a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= bus.valid && !bus.ready;
  end

  // Frame sequencer: start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (fifo_pop) begin
            shreg    <= fifo_rd;
            tx       <= 1'b0;
            baud_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (fifo_pop) begin
              shreg <= fifo_rd;
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core. Runs at 16 clocks per bit so the
// multi-frame sequences stay short; a mid-bit sampling receiver decodes tx.
module tb_uart_tx_core;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int B      = 16;          // clocks per bit at CLK_HZ / BAUD
  localparam int FRAME  = 10 * B;
  localparam int DEPTH  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx;
  logic       busy;
  logic [4:0] fifo_count;

  uart_tx_core_if bus ();

  uart_tx_core #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD_RATE   (BAUD),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // expected tx per bit slot, slot 0 = start bit
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a byte for one edge; returns 1 time unit after that edge.
  task automatic write_byte(input logic [7:0] d);
    bus.data_in = d;
    bus.valid   = 1'b1;
    tick();
    bus.valid   = 1'b0;
  endtask

  // Wait (bounded) for tx low, checking the current cycle first.
  task automatic wait_start(input int limit, output int t, output bit ok);
    ok = 1'b0;
    t  = -1;
    for (int i = 0; i <= limit; i++) begin
      if (tx === 1'b0) begin
        t  = cyc;
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  // Reference receiver: entered on the start cycle, samples each slot mid-bit,
  // counts stop-bit high cycles, returns on the last stop-bit cycle.
  task automatic rx_frame(output logic [9:0] line, output int stop_hi);
    line    = '0;
    stop_hi = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) tick();
      if (i % B == B / 2) line[i / B] = tx;
      if ((i >= 9 * B) && (tx === 1'b1)) stop_hi++;
    end
  endtask

  task automatic expect_frame(input string name, input logic [7:0] d,
                              input logic [9:0] exp_line, input int exp_t0,
                              input int limit);
    int         t;
    bit         ok;
    logic [9:0] line;
    int         hi;
    wait_start(limit, t, ok);
    check({name, " start seen"}, 32'(ok), 32'd1);
    if (!ok) return;
    check({name, " start cycle"}, t, exp_t0);
    rx_frame(line, hi);
    check({name, " line"}, 32'(line), 32'(exp_line));
    check({name, " rx byte"}, 32'(line[8:1]), 32'(d));
    check({name, " stop len"}, hi, B);
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c;
    int  n;
    int  lows;
    int  t;
    bit  ok;

    bus.data_in = 8'h00;
    bus.valid   = 1'b0;

    vecs[0] = '{data: 8'h55, line: 10'b1_01010101_0};
    vecs[1] = '{data: 8'h01, line: 10'b1_00000001_0};
    vecs[2] = '{data: 8'h80, line: 10'b1_10000000_0};
    vecs[3] = '{data: 8'hC3, line: 10'b1_11000011_0};

    // 1. Reset values, then a long idle.
    tick(); tick(); tick();
    check("rst tx", 32'(tx), 32'd1);
    check("rst ready", 32'(bus.ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst overflow", 32'(bus.overflow), 32'd0);
    check("rst fifo_count", 32'(fifo_count), 32'd0);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    check("idle tx low cycles", lows, 0);
    check("idle ready", 32'(bus.ready), 32'd1);
    check("idle busy", 32'(busy), 32'd0);
    check("idle fifo_count", 32'(fifo_count), 32'd0);

    // 2. Single frames from idle: latency, bit pattern, stop length, busy drop.
    for (int v = 0; v < 4; v++) begin
      check($sformatf("v%0d pre tx", v), 32'(tx), 32'd1);
      check($sformatf("v%0d pre busy", v), 32'(busy), 32'd0);
      write_byte(vecs[v].data);
      n = cyc;
      check($sformatf("v%0d accept count", v), 32'(fifo_count), 32'd1);
      check($sformatf("v%0d accept busy", v), 32'(busy), 32'd1);
      check($sformatf("v%0d accept tx", v), 32'(tx), 32'd1);
      expect_frame($sformatf("v%0d", v), vecs[v].data, vecs[v].line, n + 1, 4);
      check($sformatf("v%0d last stop busy", v), 32'(busy), 32'd1);
      tick();
      check($sformatf("v%0d end busy", v), 32'(busy), 32'd0);
      check($sformatf("v%0d end tx", v), 32'(tx), 32'd1);
      check($sformatf("v%0d end count", v), 32'(fifo_count), 32'd0);
    end

    // 3. Two bytes on consecutive clocks: frames back-to-back, no gap.
    write_byte(8'hA5);
    n = cyc;
    write_byte(8'h3C);
    expect_frame("b2b first", 8'hA5, 10'b1_10100101_0, n + 1, 2);
    expect_frame("b2b second", 8'h3C, 10'b1_00111100_0, n + 1 + FRAME, 2);
    tick();
    check("b2b end busy", 32'(busy), 32'd0);

    // 4. 17-byte burst fills the FIFO; two late writes overflow; order kept.
    c = cyc;
    fork
      begin
        for (int i = 0; i < 17; i++) write_byte(8'h10 + 8'(i));
        check("burst count full", 32'(fifo_count), 32'd16);
        check("burst ready low", 32'(bus.ready), 32'd0);
        write_byte(8'hE0);
        check("ovf0 pulse", 32'(bus.overflow), 32'd1);
        check("ovf0 count", 32'(fifo_count), 32'd16);
        tick();
        check("ovf0 clear", 32'(bus.overflow), 32'd0);
        write_byte(8'hE1);
        check("ovf1 pulse", 32'(bus.overflow), 32'd1);
        tick();
        check("ovf1 clear", 32'(bus.overflow), 32'd0);
      end
      begin
        for (int k = 0; k < 17; k++) begin
          logic [7:0] d;
          d = 8'h10 + 8'(k);
          expect_frame($sformatf("burst f%0d", k), d, {1'b1, d, 1'b0},
                       c + 2 + k * FRAME, FRAME);
        end
      end
    join
    wait_start(2 * FRAME, t, ok);
    check("burst no extra frame", 32'(ok), 32'd0);
    check("burst end busy", 32'(busy), 32'd0);

    // 5. Reset during bit 3 of 0xFF with four bytes queued.
    c = cyc;
    write_byte(8'hFF);
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    write_byte(8'h44);
    check("rstmid queued", 32'(fifo_count), 32'd4);
    for (int i = 0; i < FRAME && cyc < c + 2 + 4 * B + B / 2; i++) tick();
    check("rstmid at bit3", cyc, c + 2 + 4 * B + B / 2);
    check("rstmid busy before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("rstmid tx", 32'(tx), 32'd1);
    check("rstmid count", 32'(fifo_count), 32'd0);
    check("rstmid busy", 32'(busy), 32'd0);
    check("rstmid ready", 32'(bus.ready), 32'd1);
    tick(); tick();
    rst = 1'b0;
    wait_start(2 * FRAME, t, ok);
    check("rstmid no frame after", 32'(ok), 32'd0);
    check("rstmid idle busy", 32'(busy), 32'd0);

    // 6. All-zeros and all-ones through the reference receiver.
    write_byte(8'h00);
    n = cyc;
    write_byte(8'hFF);
    expect_frame("rx 00", 8'h00, 10'b1_00000000_0, n + 1, 2);
    expect_frame("rx FF", 8'hFF, 10'b1_11111111_0, n + 1 + FRAME, 2);
    tick();
    check("rx end busy", 32'(busy), 32'd0);
    check("rx end tx", 32'(tx), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
